v810_io_target: RTL

Bus responder for the V810 external bus: the I/O-space target that answers cycles driven by `v810_mem`. It decodes I/O cycles (MRQn high, ST = 2'b10) in a 256-byte window, inserts a programmable number of wait states, and terminates each cycle with READYn. It requests 16-bit dynamic bus sizing via SZRQn, and serves an 8 × 16-bit register bank: scratch registers, a free-running tick counter and an ID constant. It sits beside the ROM/RAM decode in the machine assembly and drives that assembly's `io_cen`-qualified READYn/SZRQn/data inputs.

---
 rtl/v810_bus_pkg.sv | 21 ++
 rtl/v810_io_target_if.sv | 26 ++
 rtl/v810_io_regs.sv | 68 ++++++
 rtl/v810_io_target.sv | 130 +++++++++++++
 4 files changed

// File: rtl/v810_bus_pkg.sv
// Shared definitions for the V810 external-bus I/O target: bus status codes,
// target FSM states and fixed register indices.
package v810_bus_pkg;

    localparam logic [1:0] ST_IO = 2'b10;

    localparam int         NUM_SCRATCH = 6;
    localparam logic [2:0] REG_TICK    = 3'd6;
    localparam logic [2:0] REG_ID      = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } io_state_t;

    function automatic logic io_window_hit(input logic [31:0] addr, input logic [31:0] base);
        return addr[31:8] == base[31:8];
    endfunction

endpackage

// File: rtl/v810_io_target_if.sv
// V810 external-bus signals seen by an I/O-space target; the CPU side drives
// address/control, the target answers with data and termination.
interface v810_io_target_if;
    logic [31:0] A;
    logic [31:0] D_I;
    logic [31:0] D_O;
    logic [3:0]  BEn;
    logic [1:0]  ST;
    logic        DAn;
    logic        MRQn;
    logic        RW;
    logic        BCYSTn;
    logic        READYn;
    logic        SZRQn;
    logic        SEL;

    modport master (
        output A, D_I, BEn, ST, DAn, MRQn, RW, BCYSTn,
        input  D_O, READYn, SZRQn, SEL
    );

    modport slave (
        input  A, D_I, BEn, ST, DAn, MRQn, RW, BCYSTn,
        output D_O, READYn, SZRQn, SEL
    );
endinterface

// File: rtl/v810_io_regs.sv
// Eight 16-bit I/O registers: six byte-writable scratch words, a free-running
// CE tick counter and a constant ID word.
module v810_io_regs
    import v810_bus_pkg::*;
#(
    parameter logic [15:0] ID = 16'h0810
) (
    input  logic        CLK,
    input  logic        RESn,
    input  logic        CE,
    input  logic        wr_en,
    input  logic [2:0]  idx,
    input  logic [1:0]  ben,
    input  logic [15:0] wdata,
    output logic [15:0] rdata
);

    logic [15:0] scratch_q [NUM_SCRATCH];
    logic [15:0] scratch_d [NUM_SCRATCH];
    logic [15:0] tick_q;
    logic [15:0] tick_d;

    // ben is active-high per byte lane; indices 6 and 7 match no scratch slot,
    // so writes there fall away silently.
    always_comb begin
        tick_d = tick_q;
        for (int i = 0; i < NUM_SCRATCH; i++) begin
            scratch_d[i] = scratch_q[i];
        end
        if (CE) begin
            tick_d = tick_q + 16'd1;
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                if (wr_en && idx == 3'(i)) begin
                    if (ben[0]) scratch_d[i][7:0]  = wdata[7:0];
                    if (ben[1]) scratch_d[i][15:8] = wdata[15:8];
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            tick_q <= '0;
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                scratch_q[i] <= '0;
            end
        end else begin
            tick_q <= tick_d;
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                scratch_q[i] <= scratch_d[i];
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (idx)
            REG_TICK: rdata = tick_q;
            REG_ID:   rdata = ID;
            default: begin
                for (int i = 0; i < NUM_SCRATCH; i++) begin
                    if (idx == 3'(i)) rdata = scratch_q[i];
                end
            end
        endcase
    end

endmodule

// File: rtl/v810_io_target.sv
// V810 I/O-space bus target: decodes a 256-byte I/O window, counts wait states,
// terminates with READYn and serves the v810_io_regs bank at 16-bit width.
module v810_io_target
    import v810_bus_pkg::*;
#(
    parameter logic [31:0] BASE        = 32'h0200_0000,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [15:0] ID          = 16'h0810
) (
    input  logic              CLK,
    input  logic              RESn,
    input  logic              CE,
    v810_io_target_if.slave   bus
);

    io_state_t   state_q, state_d;
    logic [3:0]  wcnt_q,  wcnt_d;
    logic [2:0]  idx_q,   idx_d;
    logic        rw_q,    rw_d;
    logic [1:0]  ben_q,   ben_d;
    logic [15:0] dout_q,  dout_d;

    logic        start;
    logic        wr_en;
    logic [15:0] rdata;
    logic        sel;
    logic        szrq_n;
    logic        ready_n;
    logic        unused_bus_bits;

    assign unused_bus_bits = ^{bus.D_I[31:16], bus.BEn[3:2], bus.A[7:4], bus.A[0]};

    assign start = CE && !bus.BCYSTn && bus.MRQn && (bus.ST == ST_IO)
                   && io_window_hit(bus.A, BASE);

    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            idx_q   <= '0;
            rw_q    <= 1'b0;
            ben_q   <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            idx_q   <= idx_d;
            rw_q    <= rw_d;
            ben_q   <= ben_d;
            dout_q  <= dout_d;
        end
    end

    // Read data is captured as the FSM enters READY so it is stable while
    // READYn is low; a write commits on the READY tick itself.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        idx_d   = idx_q;
        rw_d    = rw_q;
        ben_d   = ben_q;
        dout_d  = dout_q;
        wr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WAIT;
                    wcnt_d  = 4'(WAIT_STATES);
                    idx_d   = bus.A[3:1];
                    rw_d    = bus.RW;
                    ben_d   = ~bus.BEn[1:0];
                end
            end
            WAIT: begin
                if (CE) begin
                    if (wcnt_q != 4'd0) begin
                        wcnt_d = wcnt_q - 4'd1;
                    end else begin
                        state_d = READY;
                        if (rw_q) dout_d = rdata;
                    end
                end
            end
            READY: begin
                if (CE) begin
                    state_d = IDLE;
                    wr_en   = !rw_q && !bus.DAn;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sel     = 1'b0;
        szrq_n  = 1'b1;
        ready_n = 1'b1;
        case (state_q)
            WAIT: begin
                sel    = 1'b1;
                szrq_n = 1'b0;
            end
            READY: begin
                sel     = 1'b1;
                szrq_n  = 1'b0;
                ready_n = 1'b0;
            end
            default: ;
        endcase
    end

    v810_io_regs #(
        .ID(ID)
    ) u_regs (
        .CLK   (CLK),
        .RESn  (RESn),
        .CE    (CE),
        .wr_en (wr_en),
        .idx   (idx_q),
        .ben   (ben_q),
        .wdata (bus.D_I[15:0]),
        .rdata (rdata)
    );

    assign bus.SEL    = sel;
    assign bus.SZRQn  = szrq_n;
    assign bus.READYn = ready_n;
    assign bus.D_O    = {16'h0000, dout_q};

endmodule
